// File: rtl/cpu_dbg_pkg.sv
//------------------------------------------------------------------------------
// cpu_dbg_pkg
//
// Shared definitions for the CPU run/debug controller:
//   - encoding of the controller state as seen on the external state output
//   - clog2 helper used to size index, pointer and count fields
//
// The state encoding is visible to the board and to software, so the numeric
// values must not be reordered.
//------------------------------------------------------------------------------
package cpu_dbg_pkg;

   // Controller states (numeric values are architecturally visible)
   localparam logic [1:0] ST_IDLE = 2'd0;   // core parked, waiting for start/step
   localparam logic [1:0] ST_RUN  = 2'd1;   // free running
   localparam logic [1:0] ST_STEP = 2'd2;   // exactly one enabled cycle
   localparam logic [1:0] ST_HALT = 2'd3;   // stopped by stop pulse, breakpoint or step

   // Ceiling log2 usable in constant expressions.
   // clog2(1) = 0, clog2(2) = 1, clog2(8) = 3, clog2(9) = 4.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : cpu_dbg_pkg

// File: rtl/cpu_trace_buf.sv
//------------------------------------------------------------------------------
// cpu_trace_buf
//
// Circular PC trace buffer. Every write stores one PC; once the buffer is full
// a new write overwrites the oldest entry, so the buffer always holds the most
// recent TRACE_DEPTH executed PCs. Entries are popped oldest-first with a
// registered read (one cycle latency).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (pointers/count/read reg)
//   clear     in   synchronous flush, takes priority over write and pop
//   wr_en     in   store wr_pc this cycle
//   wr_pc     in   PC to store
//   rd_req    in   pop request; honoured only when not writing and not empty
//   rd_pc     out  popped PC, registered
//   rd_valid  out  one-cycle pulse: rd_pc was updated by a pop
//   count     out  number of entries held, saturates at TRACE_DEPTH
//------------------------------------------------------------------------------
module cpu_trace_buf
   import cpu_dbg_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int TRACE_DEPTH = 8     // power of two, >= 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        wr_en,
   input  logic [PC_WIDTH-1:0]         wr_pc,
   input  logic                        rd_req,
   output logic [PC_WIDTH-1:0]         rd_pc,
   output logic                        rd_valid,
   output logic [clog2(TRACE_DEPTH):0] count
);

   localparam int AW = clog2(TRACE_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(TRACE_DEPTH);

   // Storage has no reset so it can map onto block/distributed RAM.
   logic [PC_WIDTH-1:0] mem [TRACE_DEPTH];

   logic [AW-1:0]       wr_ptr_reg;
   logic [AW-1:0]       rd_ptr_reg;
   logic [AW:0]         count_reg;
   logic [PC_WIDTH-1:0] rd_pc_reg;
   logic                rd_valid_reg;

   logic full;
   logic empty;
   logic do_write;
   logic do_pop;

   assign full  = (count_reg == DEPTH_CNT);
   assign empty = (count_reg == '0);

   // Writes happen only while the core is enabled and pops only while it is
   // not, so they never collide; the gating below keeps that true even if a
   // caller asserts both.
   assign do_write = wr_en && !clear;
   assign do_pop   = rd_req && !wr_en && !clear && !empty;

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= wr_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (do_write) begin
         // Depth is a power of two, so pointer wrap is the natural overflow.
         wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (full) begin
            // Overwriting the oldest entry: drag the read pointer along.
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end else begin
            count_reg  <= count_reg + (AW+1)'(1);
         end
      end else if (do_pop) begin
         rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg  <= count_reg - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pc_reg    <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= do_pop;
         if (do_pop) begin
            rd_pc_reg <= mem[rd_ptr_reg];
         end
      end
   end

   assign rd_pc    = rd_pc_reg;
   assign rd_valid = rd_valid_reg;
   assign count    = count_reg;

endmodule : cpu_trace_buf

// File: rtl/cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/debug controller between the board control inputs and the pipelined CPU
// core. Sequences the core enable/start for free run, single step, external
// stop and NUM_BP PC breakpoints, and keeps a circular trace of the most
// recently executed PCs for readout while the core is not enabled.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   pulse: launch from IDLE, resume from HALT
//   step         in   pulse: one enabled cycle from IDLE or HALT
//   stop         in   pulse: force HALT from RUN
//   bp_en        in   per-breakpoint enable
//   bp_addr      in   breakpoint addresses, entry i at [i*PC_WIDTH +: PC_WIDTH]
//   pc           in   current CPU program counter
//   cpu_halt     in   core retired a HALT instruction
//   cpu_enable   out  core enable (combinational)
//   cpu_start    out  core start pulse (registered, one cycle)
//   state        out  IDLE=0, RUN=1, STEP=2, HALT=3
//   bp_hit       out  last HALT entry was caused by a breakpoint
//   bp_idx       out  index of the breakpoint that caused it
//   trace_rd     in   pop the oldest trace entry
//   trace_pc     out  popped PC, registered
//   trace_valid  out  one-cycle pulse: trace_pc holds a popped entry
//   trace_count  out  trace entries held
//------------------------------------------------------------------------------
module cpu_run_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter  int PC_WIDTH    = 8,
   parameter  int NUM_BP      = 2,   // 1..8
   parameter  int TRACE_DEPTH = 8,   // power of two, >= 2
   localparam int BP_IDX_W    = (clog2(NUM_BP) > 0) ? clog2(NUM_BP) : 1,
   localparam int CNT_W       = clog2(TRACE_DEPTH) + 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       step,
   input  logic                       stop,
   input  logic [NUM_BP-1:0]          bp_en,
   input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
   input  logic [PC_WIDTH-1:0]        pc,
   input  logic                       cpu_halt,
   output logic                       cpu_enable,
   output logic                       cpu_start,
   output logic [1:0]                 state,
   output logic                       bp_hit,
   output logic [BP_IDX_W-1:0]        bp_idx,
   input  logic                       trace_rd,
   output logic [PC_WIDTH-1:0]        trace_pc,
   output logic                       trace_valid,
   output logic [CNT_W-1:0]           trace_count
);

   logic [1:0]          state_reg;
   logic [1:0]          state_next;
   logic                skip_reg;
   logic                skip_next;
   logic                cpu_start_reg;
   logic                cpu_start_next;
   logic                bp_hit_reg;
   logic                bp_hit_next;
   logic [BP_IDX_W-1:0] bp_idx_reg;
   logic [BP_IDX_W-1:0] bp_idx_next;

   logic [NUM_BP-1:0]   bp_raw;
   logic [BP_IDX_W-1:0] bp_win;
   logic                bp_match_eff;
   logic                enable_int;
   logic                trace_clear;

   //---------------------------------------------------------------------------
   // Breakpoint comparators
   //---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp_cmp
         assign bp_raw[gi] = bp_en[gi] && (pc == bp_addr[gi*PC_WIDTH +: PC_WIDTH]);
      end
   endgenerate

   // Lowest matching index wins: scan from the top so lower indices overwrite.
   always_comb begin
      bp_win = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_raw[i]) begin
            bp_win = BP_IDX_W'(i);
         end
      end
   end

   // skip masks the breakpoint at the resume address for the first RUN cycle,
   // so a resume from a breakpoint halt executes that instruction instead of
   // halting on it again.
   assign bp_match_eff = (|bp_raw) && !skip_reg && (state_reg == ST_RUN);

   // Enable drops in the same cycle as the halting condition so the core
   // never advances past the breakpoint / stop / HALT instruction.
   assign enable_int = ((state_reg == ST_RUN) && !bp_match_eff && !stop && !cpu_halt)
                    || (state_reg == ST_STEP);

   //---------------------------------------------------------------------------
   // Run/debug FSM
   //---------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      skip_next      = skip_reg;
      cpu_start_next = 1'b0;
      bp_hit_next    = bp_hit_reg;
      bp_idx_next    = bp_idx_reg;
      trace_clear    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // A fresh launch restarts the core and discards the old trace.
            if (start) begin
               state_next     = ST_RUN;
               cpu_start_next = 1'b1;
               trace_clear    = 1'b1;
            end else if (step) begin
               state_next     = ST_STEP;
               cpu_start_next = 1'b1;
               trace_clear    = 1'b1;
            end
         end

         ST_RUN: begin
            skip_next = 1'b0;
            if (cpu_halt) begin
               state_next = ST_IDLE;
            end else if (stop) begin
               state_next  = ST_HALT;
               bp_hit_next = 1'b0;
            end else if (bp_match_eff) begin
               state_next  = ST_HALT;
               bp_hit_next = 1'b1;
               bp_idx_next = bp_win;
            end
         end

         ST_STEP: begin
            // Breakpoints are not evaluated here; a step always executes.
            if (cpu_halt) begin
               state_next = ST_IDLE;
            end else begin
               state_next  = ST_HALT;
               bp_hit_next = 1'b0;
            end
         end

         ST_HALT: begin
            // Resume continues the current program: no start pulse.
            if (start) begin
               state_next = ST_RUN;
               skip_next  = 1'b1;
            end else if (step) begin
               state_next = ST_STEP;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         skip_reg      <= 1'b0;
         cpu_start_reg <= 1'b0;
         bp_hit_reg    <= 1'b0;
         bp_idx_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         skip_reg      <= skip_next;
         cpu_start_reg <= cpu_start_next;
         bp_hit_reg    <= bp_hit_next;
         bp_idx_reg    <= bp_idx_next;
      end
   end

   //---------------------------------------------------------------------------
   // Trace buffer: records every enabled cycle; pops only while not enabled.
   //---------------------------------------------------------------------------
   cpu_trace_buf #(
      .PC_WIDTH    (PC_WIDTH),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace_buf (
      .clk      (clock),
      .rst_n    (reset),
      .clear    (trace_clear),
      .wr_en    (enable_int),
      .wr_pc    (pc),
      .rd_req   (trace_rd),
      .rd_pc    (trace_pc),
      .rd_valid (trace_valid),
      .count    (trace_count)
   );

   assign cpu_enable = enable_int;
   assign cpu_start  = cpu_start_reg;
   assign state      = state_reg;
   assign bp_hit     = bp_hit_reg;
   assign bp_idx     = bp_idx_reg;

endmodule : cpu_run_ctrl
